// File: rtl/rysy_pkg.sv
// Shared register-file types and constants for the rysy core.
package rysy_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREGS_RV32I  = 32;
  localparam int unsigned NREGS_RV32E  = 16;

  typedef enum logic [1:0] {
    RF_RESET,
    RF_CLEAR,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/reg_file_nport_if.sv
// Decode-side register file bus: NRD packed read ports, one writeback port, busy flag.
interface reg_file_nport_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) ();

  logic [NRD*AW-1:0]   rs;
  logic [NRD*XLEN-1:0] rs_d;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     rd_d;
  logic                reg_wr;
  logic                busy;

  modport master (
    output rs, rd, rd_d, reg_wr,
    input  rs_d, busy
  );

  modport slave (
    input  rs, rd, rd_d, reg_wr,
    output rs_d, busy
  );

endinterface

// File: rtl/rf_read_port.sv
// One read port: array mux, x0 forced to zero, optional write bypass, zeroed while busy.
module rf_read_port #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]   rs_i,
  input  logic [XLEN-1:0] regs_i [NREGS],
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] rd_d_i,
  input  logic            wr_en_i,
  input  logic            busy_i,
  output logic [XLEN-1:0] rs_d_o
);

  // wr_en_i is already qualified with !busy and rd != 0, so x0 is never forwarded.
  always_comb begin
    rs_d_o = '0;
    if (!busy_i && (rs_i != '0)) begin
      rs_d_o = regs_i[rs_i];
      if ((BYPASS != 0) && wr_en_i && (rs_i == rd_i)) begin
        rs_d_o = rd_d_i;
      end
    end
  end

endmodule

// File: rtl/reg_file_nport.sv
// N-read/1-write integer register file with hard-wired x0, optional bypass and a post-reset clear.
module reg_file_nport
  import rysy_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned NREGS          = NREGS_RV32I,
  parameter int unsigned NRD            = 2,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_nport_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] PtrFirst = AW'(1);
  localparam logic [AW-1:0] PtrLast  = AW'(NREGS - 1);

  if (!((NREGS == NREGS_RV32I) || (NREGS == NREGS_RV32E))) begin : g_bad_nregs
    $fatal(1, "reg_file_nport: NREGS must be 16 or 32");
  end
  if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
    $fatal(1, "reg_file_nport: NRD must be in 1..4");
  end

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            clr_en;
  logic            busy;
  logic            wr_en;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rdata [NRD];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_RESET;
      ptr_q   <= PtrFirst;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    unique case (state_q)
      RF_RESET: state_d = (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_READY;
      RF_CLEAR: begin
        clr_en = 1'b1;
        // Pointer parks at the last register rather than wrapping back to x0.
        if (ptr_q == PtrLast) begin
          state_d = RF_READY;
        end else begin
          ptr_d = ptr_q + PtrFirst;
        end
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_RESET;
    endcase
  end

  assign busy  = (state_q != RF_READY);
  assign wr_en = bus.reg_wr && !busy && (bus.rd != '0);

  // Clear and writeback are mutually exclusive (busy gates wr_en); entry 0 is never used.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs_q[ptr_q] <= '0;
    end
    if (wr_en) begin
      regs_q[bus.rd] <= bus.rd_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd_port
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW),
      .BYPASS(BYPASS)
    ) u_rd_port (
      .rs_i   (bus.rs[i*AW +: AW]),
      .regs_i (regs_q),
      .rd_i   (bus.rd),
      .rd_d_i (bus.rd_d),
      .wr_en_i(wr_en),
      .busy_i (busy),
      .rs_d_o (rdata[i])
    );
  end

  always_comb begin
    bus.rs_d = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rs_d[i*XLEN +: XLEN] = rdata[i];
    end
  end

  assign bus.busy = busy;

endmodule
